// File: rtl/phys_reg_pkg.sv
// Shared definitions for the multi-ported physical register file:
// address width helper, write-mode encodings and write-data shaping.
package phys_reg_pkg;

  localparam logic [1:0] MODE_FULL = 2'b00;
  localparam logic [1:0] MODE_LO   = 2'b01;
  localparam logic [1:0] MODE_HI   = 2'b10;

  // Widest register supported by shape_write; callers size-cast in and out.
  localparam int MAX_DATA_W = 128;

  function automatic int calc_lw(input int num_regs);
    return $clog2(num_regs);
  endfunction

  // LO keeps the low half in place, HI moves the low half up; the other half is zeroed.
  // Encoding 2'b11 behaves like MODE_FULL.
  function automatic logic [MAX_DATA_W-1:0] shape_write(
    input logic [MAX_DATA_W-1:0] data,
    input logic [1:0]            mode,
    input int                    data_w
  );
    logic [MAX_DATA_W-1:0] lo_mask;
    logic [MAX_DATA_W-1:0] result;
    int                    half;
    half    = data_w / 2;
    lo_mask = {MAX_DATA_W{1'b1}} >> (MAX_DATA_W - half);
    case (mode)
      MODE_LO: result = data & lo_mask;
      MODE_HI: result = (data & lo_mask) << half;
      default: result = data;
    endcase
    return result;
  endfunction

endpackage

// File: rtl/busy_scoreboard.sv
// Rename busy-bit tracking: writes clear, allocates set, flush clears all;
// register 0 is never busy.
module busy_scoreboard
  import phys_reg_pkg::*;
#(
  parameter int NUM_PHYS_REGS = 64,
  parameter int NUM_WR        = 2,
  parameter int NUM_ALLOC     = 2,
  parameter int LW            = calc_lw(NUM_PHYS_REGS)
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     flush_i,
  input  logic [NUM_WR-1:0]        wr_en_i,
  input  logic [NUM_WR*LW-1:0]     wr_addr_i,
  input  logic [NUM_ALLOC-1:0]     alloc_en_i,
  input  logic [NUM_ALLOC*LW-1:0]  alloc_addr_i,
  output logic [NUM_PHYS_REGS-1:0] busy_o,
  output logic [NUM_PHYS_REGS-1:0] busy_next_o
);

  logic [NUM_PHYS_REGS-1:0] busy_q;
  logic [NUM_PHYS_REGS-1:0] busy_d;

  // Allocates are applied after writes so a same-register alloc leaves the bit set.
  always_comb begin
    busy_d = busy_q;
    for (int w = 0; w < NUM_WR; w++) begin
      busy_d[wr_addr_i[w*LW +: LW]] = wr_en_i[w] ? 1'b0 : busy_d[wr_addr_i[w*LW +: LW]];
    end
    for (int a = 0; a < NUM_ALLOC; a++) begin
      busy_d[alloc_addr_i[a*LW +: LW]] = alloc_en_i[a] ? 1'b1 : busy_d[alloc_addr_i[a*LW +: LW]];
    end
    busy_d    = flush_i ? '0 : busy_d;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  assign busy_o      = busy_q;
  assign busy_next_o = busy_d;

endmodule

// File: rtl/phys_reg_file_mp.sv
// Multi-ported physical register file with write-to-read bypass,
// mode-shaped writes and registered, stallable read ports.
module phys_reg_file_mp
  import phys_reg_pkg::*;
#(
  parameter  int NUM_PHYS_REGS = 64,
  parameter  int DATA_W        = 64,
  parameter  int NUM_RD        = 4,
  parameter  int NUM_WR        = 2,
  parameter  int NUM_ALLOC     = 2,
  localparam int LW            = calc_lw(NUM_PHYS_REGS)
) (
  input  logic                     CLK,
  input  logic                     RESET_N,
  input  logic                     STALL,
  input  logic                     FLUSH_IN,
  input  logic [NUM_RD-1:0]        RD_EN_IN,
  input  logic [NUM_RD*LW-1:0]     RD_ADDR_IN,
  output logic [NUM_RD*DATA_W-1:0] RD_DATA_OUT,
  output logic [NUM_RD-1:0]        RD_VALID_OUT,
  output logic [NUM_RD-1:0]        RD_BUSY_OUT,
  input  logic [NUM_WR-1:0]        WR_EN_IN,
  input  logic [NUM_WR*LW-1:0]     WR_ADDR_IN,
  input  logic [NUM_WR*DATA_W-1:0] WR_DATA_IN,
  input  logic [NUM_WR*2-1:0]      WR_MODE_IN,
  input  logic [NUM_ALLOC-1:0]     ALLOC_EN_IN,
  input  logic [NUM_ALLOC*LW-1:0]  ALLOC_ADDR_IN,
  output logic [NUM_PHYS_REGS-1:0] BUSY_OUT
);

  logic [DATA_W-1:0]        regs_q [NUM_PHYS_REGS];
  logic [LW-1:0]            wr_addr [NUM_WR];
  logic [DATA_W-1:0]        wr_val [NUM_WR];
  logic [NUM_WR-1:0]        wr_act;
  logic [NUM_PHYS_REGS-1:0] busy_next;
  logic [LW-1:0]            rd_addr [NUM_RD];
  logic [DATA_W-1:0]        rd_data_d [NUM_RD];
  logic [NUM_RD-1:0]        rd_busy_d;
  logic [DATA_W-1:0]        rd_data_q [NUM_RD];
  logic [NUM_RD-1:0]        rd_valid_q;
  logic [NUM_RD-1:0]        rd_busy_q;

  busy_scoreboard #(
    .NUM_PHYS_REGS (NUM_PHYS_REGS),
    .NUM_WR        (NUM_WR),
    .NUM_ALLOC     (NUM_ALLOC),
    .LW            (LW)
  ) u_busy (
    .clk_i        (CLK),
    .rst_ni       (RESET_N),
    .flush_i      (FLUSH_IN),
    .wr_en_i      (WR_EN_IN),
    .wr_addr_i    (WR_ADDR_IN),
    .alloc_en_i   (ALLOC_EN_IN),
    .alloc_addr_i (ALLOC_ADDR_IN),
    .busy_o       (BUSY_OUT),
    .busy_next_o  (busy_next)
  );

  // Writes to register 0 are dropped here so neither the array nor the bypass sees them.
  always_comb begin
    for (int w = 0; w < NUM_WR; w++) begin
      wr_addr[w] = WR_ADDR_IN[w*LW +: LW];
      wr_act[w]  = WR_EN_IN[w] && (wr_addr[w] != '0);
      wr_val[w]  = DATA_W'(shape_write(MAX_DATA_W'(WR_DATA_IN[w*DATA_W +: DATA_W]),
                                       WR_MODE_IN[w*2 +: 2], DATA_W));
    end
  end

  // Later ports are assigned last, so the highest-index port wins on a collision.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      regs_q <= '{default: '0};
    end else begin
      for (int w = 0; w < NUM_WR; w++) begin
        if (wr_act[w]) begin
          regs_q[wr_addr[w]] <= wr_val[w];
        end
      end
    end
  end

  always_comb begin
    for (int r = 0; r < NUM_RD; r++) begin
      rd_addr[r]   = RD_ADDR_IN[r*LW +: LW];
      rd_data_d[r] = regs_q[rd_addr[r]];
      rd_busy_d[r] = BUSY_OUT[rd_addr[r]];
      for (int w = 0; w < NUM_WR; w++) begin
        rd_data_d[r] = (wr_act[w] && wr_addr[w] == rd_addr[r]) ? wr_val[w] : rd_data_d[r];
        rd_busy_d[r] = (wr_act[w] && wr_addr[w] == rd_addr[r]) ? busy_next[rd_addr[r]]
                                                                : rd_busy_d[r];
      end
    end
  end

  // Idle ports keep their last data/busy; only valid drops.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      rd_data_q  <= '{default: '0};
      rd_valid_q <= '0;
      rd_busy_q  <= '0;
    end else if (!STALL) begin
      rd_valid_q <= RD_EN_IN;
      for (int r = 0; r < NUM_RD; r++) begin
        if (RD_EN_IN[r]) begin
          rd_data_q[r] <= rd_data_d[r];
          rd_busy_q[r] <= rd_busy_d[r];
        end
      end
    end
  end

  for (genvar r = 0; r < NUM_RD; r++) begin : g_rd_out
    assign RD_DATA_OUT[r*DATA_W +: DATA_W] = rd_data_q[r];
  end

  assign RD_VALID_OUT = rd_valid_q;
  assign RD_BUSY_OUT  = rd_busy_q;

endmodule

// File: tb/tb_phys_reg_file_mp.sv
// Scoreboard bench for phys_reg_file_mp: read requests push expected responses,
// a negedge monitor pops and compares them whenever a read port presents valid data.
module tb_phys_reg_file_mp;

  localparam int NPR = 64;
  localparam int DW  = 64;
  localparam int NRD = 4;
  localparam int NWR = 2;
  localparam int NAL = 2;
  localparam int LW  = 6;

  logic            CLK = 1'b0;
  logic            RESET_N;
  logic            STALL;
  logic            FLUSH_IN;
  logic [NRD-1:0]    RD_EN_IN;
  logic [NRD*LW-1:0] RD_ADDR_IN;
  logic [NRD*DW-1:0] RD_DATA_OUT;
  logic [NRD-1:0]    RD_VALID_OUT;
  logic [NRD-1:0]    RD_BUSY_OUT;
  logic [NWR-1:0]    WR_EN_IN;
  logic [NWR*LW-1:0] WR_ADDR_IN;
  logic [NWR*DW-1:0] WR_DATA_IN;
  logic [NWR*2-1:0]  WR_MODE_IN;
  logic [NAL-1:0]    ALLOC_EN_IN;
  logic [NAL*LW-1:0] ALLOC_ADDR_IN;
  logic [NPR-1:0]    BUSY_OUT;

  phys_reg_file_mp #(
    .NUM_PHYS_REGS (NPR),
    .DATA_W        (DW),
    .NUM_RD        (NRD),
    .NUM_WR        (NWR),
    .NUM_ALLOC     (NAL)
  ) dut (
    .CLK           (CLK),
    .RESET_N       (RESET_N),
    .STALL         (STALL),
    .FLUSH_IN      (FLUSH_IN),
    .RD_EN_IN      (RD_EN_IN),
    .RD_ADDR_IN    (RD_ADDR_IN),
    .RD_DATA_OUT   (RD_DATA_OUT),
    .RD_VALID_OUT  (RD_VALID_OUT),
    .RD_BUSY_OUT   (RD_BUSY_OUT),
    .WR_EN_IN      (WR_EN_IN),
    .WR_ADDR_IN    (WR_ADDR_IN),
    .WR_DATA_IN    (WR_DATA_IN),
    .WR_MODE_IN    (WR_MODE_IN),
    .ALLOC_EN_IN   (ALLOC_EN_IN),
    .ALLOC_ADDR_IN (ALLOC_ADDR_IN),
    .BUSY_OUT      (BUSY_OUT)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [1:0]  port;
    logic [63:0] data;
    logic        busy;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  logic stall_seen = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // STALL as seen by the DUT at the last edge: outputs are only new when it was low.
  always @(posedge CLK) stall_seen <= STALL;

  always @(negedge CLK) begin
    if (RESET_N === 1'b1 && stall_seen === 1'b0) begin
      for (int p = 0; p < NRD; p++) begin
        if (RD_VALID_OUT[p] === 1'b1) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_valid port=%0d actual=1 required=0", p);
          end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("mon_port", 64'(p), 64'(e.port));
            chk("mon_data", RD_DATA_OUT[p*DW +: DW], e.data);
            chk("mon_busy", 64'(RD_BUSY_OUT[p]), 64'(e.busy));
          end
        end
      end
    end
  end

  task automatic clear();
    RD_EN_IN    = '0;
    WR_EN_IN    = '0;
    ALLOC_EN_IN = '0;
    FLUSH_IN    = 1'b0;
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
    clear();
  endtask

  task automatic wr(input int p, input int a, input logic [63:0] d, input logic [1:0] m);
    WR_EN_IN[p]            = 1'b1;
    WR_ADDR_IN[p*LW +: LW] = a[LW-1:0];
    WR_DATA_IN[p*DW +: DW] = d;
    WR_MODE_IN[p*2 +: 2]   = m;
  endtask

  task automatic al(input int p, input int a);
    ALLOC_EN_IN[p]            = 1'b1;
    ALLOC_ADDR_IN[p*LW +: LW] = a[LW-1:0];
  endtask

  task automatic rd(input int p, input int a, input logic [63:0] d, input logic b);
    exp_t e;
    RD_EN_IN[p]            = 1'b1;
    RD_ADDR_IN[p*LW +: LW] = a[LW-1:0];
    e.port = p[1:0];
    e.data = d;
    e.busy = b;
    exp_q.push_back(e);
  endtask

  initial begin
    RESET_N       = 1'b0;
    STALL         = 1'b0;
    RD_ADDR_IN    = '0;
    WR_ADDR_IN    = '0;
    WR_DATA_IN    = '0;
    WR_MODE_IN    = '0;
    ALLOC_ADDR_IN = '0;
    clear();
    #3;
    chk("reset_valid", 64'(RD_VALID_OUT), 64'h0);
    chk("reset_data0", RD_DATA_OUT[63:0], 64'h0);
    chk("reset_busy_out", BUSY_OUT, 64'h0);
    @(negedge CLK);
    RESET_N = 1'b1;

    // Full write then read back
    wr(0, 5, 64'h1122334455667788, 2'b00); step();
    rd(0, 5, 64'h1122334455667788, 1'b0); step();
    chk("busy_after_write", BUSY_OUT, 64'h0);

    // Allocate sets busy, write clears it
    al(0, 20); step();
    chk("busy_alloc20", BUSY_OUT, 64'h0000_0000_0010_0000);
    rd(1, 20, 64'h0, 1'b1); step();
    wr(1, 20, 64'h77, 2'b11); step();
    chk("busy_clear20", BUSY_OUT, 64'h0);
    rd(2, 20, 64'h77, 1'b0); step();

    // Same-register write collision with bypass read: port 1 wins
    wr(0, 9, 64'hA, 2'b00); wr(1, 9, 64'hB, 2'b00); rd(2, 9, 64'hB, 1'b0); step();
    rd(0, 9, 64'hB, 1'b0); step();

    // Half-width modes
    wr(0, 7, 64'hDEADBEEF, 2'b10); step();
    rd(0, 7, 64'hDEADBEEF00000000, 1'b0); step();
    wr(1, 7, 64'hFFFFFFFFDEADBEEF, 2'b01); rd(1, 7, 64'h00000000DEADBEEF, 1'b0); step();
    rd(3, 7, 64'h00000000DEADBEEF, 1'b0); step();

    // Allocate and write the same register, then flush overriding allocates
    al(0, 12); wr(0, 12, 64'h1212, 2'b00); rd(3, 12, 64'h1212, 1'b1); step();
    chk("busy12", BUSY_OUT, 64'h0000_0000_0000_1000);
    rd(0, 12, 64'h1212, 1'b1); step();
    FLUSH_IN = 1'b1; al(0, 3); al(1, 12); step();
    chk("busy_flush", BUSY_OUT, 64'h0);

    // Register 0 ignores writes and allocates
    wr(0, 0, 64'hFFFF, 2'b00); al(0, 0); rd(0, 0, 64'h0, 1'b0); step();
    chk("busy_reg0", BUSY_OUT, 64'h0);
    rd(1, 0, 64'h0, 1'b0); step();

    // Stall freezes read outputs while a write still commits
    rd(0, 5, 64'h1122334455667788, 1'b0); step();
    STALL = 1'b1;
    wr(0, 4, 64'h55, 2'b00);
    for (int i = 0; i < 3; i++) begin
      RD_EN_IN   = '1;
      RD_ADDR_IN = {6'(4 + i), 6'(9), 6'(7), 6'(4)};
      step();
      chk("stall_data0", RD_DATA_OUT[63:0], 64'h1122334455667788);
      chk("stall_valid", 64'(RD_VALID_OUT), 64'h1);
    end
    STALL = 1'b0;
    rd(0, 4, 64'h55, 1'b0); step();

    // Reset in the middle of a stall
    STALL = 1'b1; al(0, 30); step();
    chk("busy_alloc30", BUSY_OUT, 64'h0000_0000_4000_0000);
    chk("held_data0", RD_DATA_OUT[63:0], 64'h55);
    wr(0, 6, 64'h66, 2'b00); al(1, 31);
    RESET_N = 1'b0;
    #1;
    chk("midreset_valid", 64'(RD_VALID_OUT), 64'h0);
    for (int p = 0; p < NRD; p++) chk("midreset_data", RD_DATA_OUT[p*DW +: DW], 64'h0);
    chk("midreset_busy_out", BUSY_OUT, 64'h0);
    clear();
    STALL = 1'b0;
    @(negedge CLK);
    RESET_N = 1'b1;
    rd(0, 6, 64'h0, 1'b0); rd(1, 5, 64'h0, 1'b0); step();
    chk("post_reset_busy_out", BUSY_OUT, 64'h0);

    for (int i = 0; i < 3; i++) step();
    chk("queue_empty", 64'(exp_q.size()), 64'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/phys_reg_file_mp.md
PHYS_REG_FILE_MP -- requirements
Module: phys_reg_file_mp

Interface
REQ-001 Parameter NUM_PHYS_REGS, default 64, number of physical registers (power of two, 32 or more).
REQ-002 Parameter DATA_W, default 64, register width (even).
REQ-003 Parameter NUM_RD, default 4, number of read ports.
REQ-004 Parameter NUM_WR, default 2, number of write ports.
REQ-005 Parameter NUM_ALLOC, default 2, number of rename busy-set ports; LW = clog2(NUM_PHYS_REGS).
REQ-006 CLK  in  1  single clock; all state on rising edge.
REQ-007 RESET_N  in  1  reset, asynchronous and active-low.
REQ-008 STALL  in  1  holds the read-output registers.
REQ-009 FLUSH_IN  in  1  clears all busy bits.
REQ-010 RD_EN_IN  in  NUM_RD  per-port read request.
REQ-011 RD_ADDR_IN  in  NUM_RD*LW  per-port read address.
REQ-012 RD_DATA_OUT  out  NUM_RD*DATA_W  registered read data.
REQ-013 RD_VALID_OUT  out  NUM_RD  registered read valid.
REQ-014 RD_BUSY_OUT  out  NUM_RD  registered busy bit of the address read.
REQ-015 WR_EN_IN  in  NUM_WR  per-port write enable.
REQ-016 WR_ADDR_IN  in  NUM_WR*LW  write address.
REQ-017 WR_DATA_IN  in  NUM_WR*DATA_W  write data.
REQ-018 WR_MODE_IN  in  NUM_WR*2  write mode: 00 full, 01 LO (low half = data low half, upper half zeroed), 10 HI (upper half = data low half, low half zeroed), 11 full.
REQ-019 ALLOC_EN_IN  in  NUM_ALLOC  rename allocate valid.
REQ-020 ALLOC_ADDR_IN  in  NUM_ALLOC*LW  register to mark busy.
REQ-021 BUSY_OUT  out  NUM_PHYS_REGS  current busy vector, driven straight from state.

Function
REQ-022 Register 0 SHALL read as zero, never be busy, and ignore writes and allocates.
REQ-023 Writes SHALL commit at the clock edge when WR_EN is set, regardless of STALL.
REQ-024 Each write SHALL clear the busy bit of its target register.
REQ-025 When two write ports target the same register in one cycle, the highest-index port SHALL win for both data and mode.
REQ-026 Each allocate SHALL set the target register's busy bit at the clock edge, regardless of STALL.
REQ-027 If an allocate and a write target the same register in one cycle, the data SHALL be written and the busy bit SHALL end set.
REQ-028 FLUSH_IN SHALL clear every busy bit, overriding same-cycle allocates; same-cycle writes SHALL still commit data.
REQ-029 Read latency SHALL be 1 cycle: RD_DATA, RD_VALID and RD_BUSY are sampled at the edge following the request.
REQ-030 Bypass: a read address matching a same-cycle write SHALL return the post-write value (after mode shaping and port priority) and RD_BUSY = 0, unless a same-cycle allocate also hits it, in which case RD_BUSY = 1.
REQ-031 While STALL = 1, RD_DATA_OUT, RD_VALID_OUT and RD_BUSY_OUT SHALL hold their values.
REQ-032 A port with RD_EN = 0 SHALL drive RD_VALID = 0; its data and busy outputs SHALL hold their previous values.
REQ-033 BUSY_OUT SHALL reflect the updated state in the cycle after an allocate, write or flush.

Reset
REQ-034 Asserting RESET_N low SHALL immediately zero all registers, all busy bits, RD_DATA_OUT, RD_VALID_OUT and RD_BUSY_OUT.
REQ-035 Writes, allocates and flushes presented in the same cycle that reset asserts SHALL be lost.
REQ-036 The first operation after deassertion SHALL take effect at the first rising edge with RESET_N high.

Structure
REQ-037 Package phys_reg_pkg SHALL hold LW computation, WR_MODE encodings (MODE_FULL, MODE_LO, MODE_HI) and a write-shaping function.
REQ-038 Busy tracking SHALL be the sub-module busy_scoreboard, covering alloc/write/flush priority and BUSY_OUT.
REQ-039 The data array and bypass network SHALL stay in phys_reg_file_mp.

Verification
REQ-040 Reset, then write port 0 reg 5 = 0x1122334455667788 FULL; next cycle read reg 5 -> RD_DATA 0x1122334455667788, VALID 1, BUSY 0 one cycle later.
REQ-041 Same cycle: WR0 reg 9 = 0xA, WR1 reg 9 = 0xB, read reg 9 -> read returns 0xB (bypass plus priority); a later read also returns 0xB.
REQ-042 Write reg 7 data 0xDEADBEEF with MODE_HI -> read reg 7 = 0xDEADBEEF00000000; MODE_LO -> 0x00000000DEADBEEF.
REQ-043 Allocate reg 12 and write reg 12 in the same cycle -> BUSY_OUT[12] = 1 next cycle and data updated; then FLUSH with allocate reg 3 -> BUSY_OUT all zero.
REQ-044 Write and allocate reg 0, then read reg 0 -> data 0, BUSY 0, BUSY_OUT[0] = 0.
REQ-045 Hold STALL = 1 three cycles while writing reg 4 = 0x55 and changing read addresses -> read outputs frozen; write visible on the first read after STALL drops; RESET_N low mid-stall clears all outputs immediately.
